// File: rtl/spi_adc_master_if.sv
// spi_adc_master_if
//   Request/result bus between the SPI ADC master and the sample consumer.
//
//   Handshake: start is a request level that the master samples only while
//   it is idle; a start seen while busy=1 is dropped, not queued. valid is a
//   one-cycle pulse with no back-pressure: the consumer must take data_out
//   (and lz_err when present) in the cycle valid is high. data_out holds its
//   value between pulses.
//
//   Signals:
//     start    requester -> master  conversion request
//     busy     master -> requester  high while a frame or its CS hold runs
//     valid    master -> requester  one-cycle result strobe
//     data_out master -> requester  channel i in [i*DATA_W +: DATA_W]
//     lz_err   master -> requester  leading-zero violation flag (only with
//                                   SPI_ADC_LEADZERO_CHECK_EN defined)
//
//   Modports: master = the requesting side, slave = the SPI master block.
interface spi_adc_master_if #(
  parameter int DATA_W = 16,
  parameter int N_CH   = 2
);
  logic                   start;
  logic                   busy;
  logic                   valid;
  logic [N_CH*DATA_W-1:0] data_out;
`ifdef SPI_ADC_LEADZERO_CHECK_EN
  logic                   lz_err;

  modport master (output start, input busy, input valid, input data_out, input lz_err);
  modport slave  (input start, output busy, output valid, output data_out, output lz_err);
`else
  modport master (output start, input busy, input valid, input data_out);
  modport slave  (input start, output busy, output valid, output data_out);
`endif
endinterface

// File: rtl/spi_adc_master.sv
// spi_adc_master
//   SPI receive master for serial ADCs (e.g. PMOD AD1: two AD7476 sharing
//   CS and SCLK, one MISO each). One framed conversion per accepted start:
//   cs_n low, CS_SETUP idle clocks, DATA_W SCLK periods of CLK_DIV clocks
//   (CPOL=0, high half first), every MISO line sampled at the end of the
//   low half, then cs_n high for CS_HOLD clocks before the next start.
//   All channel words are published together with a one-cycle valid.
//
//   Optional feature macro: SPI_ADC_LEADZERO_CHECK_EN adds parameter LZ_BITS
//   and bus signal lz_err (set on valid when any channel has a non-zero bit
//   in its top LZ_BITS bits, cleared otherwise, held like data_out).
//
//   Ports:
//     clk        system clock, rising edge
//     rst        asynchronous, active-high reset
//     miso       serial data, bit i = channel i
//     cs_n       chip select, active low, registered
//     sck        serial clock, CPOL=0, registered
//     bus        spi_adc_master_if.slave: start, busy, valid, data_out[, lz_err]
//     state_dbg  current FSM state (0 idle, 1 setup, 2 shift, 3 hold)
module spi_adc_master #(
  parameter int DATA_W   = 16,
  parameter int N_CH     = 2,
  parameter int CLK_DIV  = 8,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
`ifdef SPI_ADC_LEADZERO_CHECK_EN
  ,
  parameter int LZ_BITS  = 4
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   miso,
  output logic              cs_n,
  output logic              sck,
  spi_adc_master_if.slave   bus,
  output logic [1:0]        state_dbg
);

  localparam int HALF    = CLK_DIV / 2;
  localparam int CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam int P_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int B_W     = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  if (DATA_W < 2) begin : g_bad_data_w
    $error("spi_adc_master: DATA_W must be >= 2");
  end
  if (N_CH < 1) begin : g_bad_n_ch
    $error("spi_adc_master: N_CH must be >= 1");
  end
  if ((CLK_DIV < 2) || (CLK_DIV % 2 != 0)) begin : g_bad_clk_div
    $error("spi_adc_master: CLK_DIV must be even and >= 2");
  end
  if (CS_SETUP < 1) begin : g_bad_cs_setup
    $error("spi_adc_master: CS_SETUP must be >= 1");
  end
  if (CS_HOLD < 1) begin : g_bad_cs_hold
    $error("spi_adc_master: CS_HOLD must be >= 1");
  end
`ifdef SPI_ADC_LEADZERO_CHECK_EN
  if ((LZ_BITS < 1) || (LZ_BITS > DATA_W)) begin : g_bad_lz_bits
    $error("spi_adc_master: LZ_BITS must be in 1..DATA_W");
  end
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                      state;
  logic [CNT_W-1:0]            cnt;      // SETUP / HOLD cycle counter
  logic [P_W-1:0]              phase;    // position inside one SCLK period
  logic [P_W:0]                phase_inc;
  logic [B_W-1:0]              bit_cnt;
  logic [N_CH-1:0][DATA_W-1:0] shreg;
  logic [N_CH-1:0][DATA_W-1:0] shreg_next;
  logic                        valid_q;
  logic [N_CH*DATA_W-1:0]      data_q;

  // Shift registers with the current MISO bit appended; used both for the
  // per-bit shift and for loading data_out on the last bit.
  always_comb begin
    shreg_next = shreg;
    for (int i = 0; i < N_CH; i++) begin
      shreg_next[i] = {shreg[i][DATA_W-2:0], miso[i]};
    end
  end

  assign phase_inc = {1'b0, phase} + (P_W+1)'(1);

`ifdef SPI_ADC_LEADZERO_CHECK_EN
  logic lz_q;
  logic lz_next;

  always_comb begin
    lz_next = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (|shreg_next[i][DATA_W-1 -: LZ_BITS]) lz_next = 1'b1;
    end
  end

  assign bus.lz_err = lz_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cs_n    <= 1'b1;
      sck     <= 1'b0;
      cnt     <= '0;
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef SPI_ADC_LEADZERO_CHECK_EN
      lz_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_SETUP;
            cs_n  <= 1'b0;
            cnt   <= '0;
            shreg <= '0;
          end
        end
        S_SETUP: begin
          if (cnt == CNT_W'(CS_SETUP - 1)) begin
            // First SCLK period starts with its high half.
            state   <= S_SHIFT;
            sck     <= 1'b1;
            phase   <= '0;
            bit_cnt <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (phase == P_W'(CLK_DIV - 1)) begin
            // End of the low half: the slave updated on the falling edge
            // HALF clocks ago, so the line is settled.
            shreg <= shreg_next;
            phase <= '0;
            if (bit_cnt == B_W'(DATA_W - 1)) begin
              state   <= S_HOLD;
              cs_n    <= 1'b1;
              sck     <= 1'b0;
              cnt     <= '0;
              valid_q <= 1'b1;
              data_q  <= shreg_next;
`ifdef SPI_ADC_LEADZERO_CHECK_EN
              lz_q    <= lz_next;
`endif
            end else begin
              bit_cnt <= bit_cnt + B_W'(1);
              sck     <= 1'b1;
            end
          end else begin
            phase <= phase_inc[P_W-1:0];
            sck   <= (phase_inc < (P_W+1)'(HALF));
          end
        end
        S_HOLD: begin
          if (cnt == CNT_W'(CS_HOLD - 1)) begin
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != S_IDLE);
  assign bus.valid    = valid_q;
  assign bus.data_out = data_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_spi_adc_master.sv
// tb_spi_adc_master
//   Bench for spi_adc_master: a default-parameter instance (16 bit, 2 ch,
//   CLK_DIV 8) and a small instance (12 bit, 1 ch, CLK_DIV 2, CS_SETUP 1).
//   Behavioural ADC slaves shift words out on SCLK falling edges; expected
//   words and valid cycles are queued when stimulus is issued and popped by
//   monitors on each valid. Honours SPI_ADC_LEADZERO_CHECK_EN.
module tb_spi_adc_master;

  localparam int DW     = 16;
  localparam int NC     = 2;
  localparam int CD     = 8;
  localparam int CSS    = 2;
  localparam int CSH    = 2;
  localparam int LAT    = CSS + DW * CD;      // start edge -> valid edge
  localparam int PERIOD = LAT + CSH + 1;      // back-to-back frame period
  localparam int DW1    = 12;
  localparam int CD1    = 2;
  localparam int CSS1   = 1;
  localparam int LAT1   = CSS1 + DW1 * CD1;
  localparam int LZB    = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- DUTs ----------------
  logic [NC-1:0] miso0 = '0;
  logic          cs_n0, sck0;
  logic [1:0]    st0;
  logic [0:0]    miso1 = '0;
  logic          cs_n1, sck1;
  logic [1:0]    st1;

  spi_adc_master_if #(.DATA_W(DW),  .N_CH(NC)) bus0 ();
  spi_adc_master_if #(.DATA_W(DW1), .N_CH(1))  bus1 ();

  spi_adc_master #(.DATA_W(DW), .N_CH(NC), .CLK_DIV(CD), .CS_SETUP(CSS), .CS_HOLD(CSH)) dut0 (
    .clk(clk), .rst(rst), .miso(miso0), .cs_n(cs_n0), .sck(sck0), .bus(bus0), .state_dbg(st0)
  );

  spi_adc_master #(.DATA_W(DW1), .N_CH(1), .CLK_DIV(CD1), .CS_SETUP(CSS1), .CS_HOLD(2)) dut1 (
    .clk(clk), .rst(rst), .miso(miso1), .cs_n(cs_n1), .sck(sck1), .bus(bus1), .state_dbg(st1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

`ifdef SPI_ADC_LEADZERO_CHECK_EN
  // A channel violates when its value reaches 2^(width - LZB).
  function automatic logic lz_model0(input logic [NC*DW-1:0] w);
    logic [DW-1:0] ch;
    lz_model0 = 1'b0;
    for (int c = 0; c < NC; c++) begin
      ch = w[c*DW +: DW];
      if (ch >= DW'(1 << (DW - LZB))) lz_model0 = 1'b1;
    end
  endfunction

  function automatic logic lz_model1(input logic [DW1-1:0] w);
    lz_model1 = (w >= DW1'(1 << (DW1 - LZB)));
  endfunction
`endif

  // ---------------- ADC slave models ----------------
  // Each bit is put on the line at a SCLK falling edge, MSB first.
  logic [NC*DW-1:0] word_q[$];
  logic [NC*DW-1:0] cur0 = '0;
  int               bidx0 = DW;
  logic [DW1-1:0]   word1_q[$];
  logic [DW1-1:0]   cur1 = '0;
  int               bidx1 = DW1;

  always @(negedge cs_n0) begin
    cur0  = (word_q.size() > 0) ? word_q.pop_front() : '0;
    bidx0 = DW;
  end
  always @(negedge sck0) begin
    if (!cs_n0 && bidx0 > 0) begin
      bidx0--;
      for (int c = 0; c < NC; c++) miso0[c] = cur0[c*DW + bidx0];
    end
  end

  always @(negedge cs_n1) begin
    cur1  = (word1_q.size() > 0) ? word1_q.pop_front() : '0;
    bidx1 = DW1;
  end
  always @(negedge sck1) begin
    if (!cs_n1 && bidx1 > 0) begin
      bidx1--;
      miso1[0] = cur1[bidx1];
    end
  end

  // ---------------- scoreboard ----------------
  logic [NC*DW-1:0] exp_q[$];
  int               edge_q[$];
  logic [DW1-1:0]   exp1_q[$];
  int               edge1_q[$];
  logic [NC*DW-1:0] held0 = '0;
  logic [DW1-1:0]   held1 = '0;
  logic [NC*DW-1:0] e0;
  logic [DW1-1:0]   e1;
  int               ed0, ed1;
`ifdef SPI_ADC_LEADZERO_CHECK_EN
  logic             held_lz0 = 1'b0;
  logic             held_lz1 = 1'b0;
`endif

  always @(negedge clk) begin
    if (rst) begin
      held0 = '0;
      check("rst_valid0", 64'(bus0.valid), 64'(0));
      check("rst_data0", 64'(bus0.data_out), 64'(0));
`ifdef SPI_ADC_LEADZERO_CHECK_EN
      held_lz0 = 1'b0;
      check("rst_lz0", 64'(bus0.lz_err), 64'(0));
`endif
    end else if (bus0.valid) begin
      check("valid0_expected", 64'(exp_q.size() > 0), 64'(1));
      if (exp_q.size() > 0) begin
        e0  = exp_q.pop_front();
        ed0 = edge_q.pop_front();
        check("data0", 64'(bus0.data_out), 64'(e0));
        check("latency0", 64'(cyc), 64'(ed0));
        held0 = e0;
`ifdef SPI_ADC_LEADZERO_CHECK_EN
        held_lz0 = lz_model0(e0);
        check("lz0", 64'(bus0.lz_err), 64'(held_lz0));
`endif
      end
    end else begin
      check("hold0", 64'(bus0.data_out), 64'(held0));
`ifdef SPI_ADC_LEADZERO_CHECK_EN
      check("hold_lz0", 64'(bus0.lz_err), 64'(held_lz0));
`endif
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      held1 = '0;
`ifdef SPI_ADC_LEADZERO_CHECK_EN
      held_lz1 = 1'b0;
`endif
    end else if (bus1.valid) begin
      check("valid1_expected", 64'(exp1_q.size() > 0), 64'(1));
      if (exp1_q.size() > 0) begin
        e1  = exp1_q.pop_front();
        ed1 = edge1_q.pop_front();
        check("data1", 64'(bus1.data_out), 64'(e1));
        check("latency1", 64'(cyc), 64'(ed1));
        held1 = e1;
`ifdef SPI_ADC_LEADZERO_CHECK_EN
        held_lz1 = lz_model1(e1);
        check("lz1", 64'(bus1.lz_err), 64'(held_lz1));
`endif
      end
    end else begin
      check("hold1", 64'(bus1.data_out), 64'(held1));
`ifdef SPI_ADC_LEADZERO_CHECK_EN
      check("hold_lz1", 64'(bus1.lz_err), 64'(held_lz1));
`endif
    end
  end

  // ---------------- SPI waveform monitor (dut0) ----------------
  int   lowrun = 0, highrun = 0, hr = 0, lr = 0, rises = 0;
  logic pcs = 1'b1, psck = 1'b0;
  bit   btb_mode = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      lowrun = 0; highrun = 0; hr = 0; lr = 0; rises = 0;
      pcs = 1'b1; psck = 1'b0;
      check("rst_cs_n0", 64'(cs_n0), 64'(1));
      check("rst_sck0", 64'(sck0), 64'(0));
    end else begin
      if (sck0 && !psck) begin
        if (rises == 0) check("cs_setup0", 64'(lowrun), 64'(CSS));
        else            check("sck_low0", 64'(lr), 64'(CD / 2));
        rises++;
      end
      if (!sck0 && psck) check("sck_high0", 64'(hr), 64'(CD / 2));
      if (cs_n0 && !pcs && lowrun > 0) begin
        check("cs_low_len0", 64'(lowrun), 64'(LAT));
        check("sck_rises0", 64'(rises), 64'(DW));
        rises = 0;
      end
      if (!cs_n0 && pcs && btb_mode) check("cs_gap0", 64'(highrun), 64'(CSH + 1));
      check("sck_idle_low0", 64'(cs_n0 && sck0), 64'(0));
      hr      = sck0 ? hr + 1 : 0;
      lr      = sck0 ? 0 : lr + 1;
      lowrun  = cs_n0 ? 0 : lowrun + 1;
      highrun = cs_n0 ? highrun + 1 : 0;
      psck    = sck0;
      pcs     = cs_n0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_idle(input int which, input string name);
    int n = 0;
    while (((which == 0) ? bus0.busy : bus1.busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'((which == 0) ? bus0.busy : bus1.busy), 64'(0));
  endtask

  task automatic frame0(input logic [NC*DW-1:0] w, input int width);
    word_q.push_back(w);
    exp_q.push_back(w);
    edge_q.push_back(cyc + 1 + LAT);
    bus0.start = 1'b1;
    repeat (width) @(negedge clk);
    bus0.start = 1'b0;
  endtask

  task automatic frame1(input logic [DW1-1:0] w);
    word1_q.push_back(w);
    exp1_q.push_back(w);
    edge1_q.push_back(cyc + 1 + LAT1);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    int               s;
    logic [NC*DW-1:0] w;
    logic [DW1-1:0]   w1;
    logic [15:0]      pats[3];
    pats = '{16'h0001, 16'h0800, 16'h0FFF};
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy0", 64'(bus0.busy), 64'(0));
    check("rst_busy1", 64'(bus1.busy), 64'(0));
    check("rst_cs_n1", 64'(cs_n1), 64'(1));
    #2 rst = 1'b0;
    @(negedge clk);

    // Directed frame: ch0 0x0ABC, ch1 0x0F0F.
    frame0({16'h0F0F, 16'h0ABC}, 1);
    check("busy0_after_start", 64'(bus0.busy), 64'(1));
    wait_idle(0, "idle_t1");
    check("pending_t1", 64'(exp_q.size()), 64'(0));

    // start re-pulsed at bit 7 and during HOLD must be ignored.
    s = cyc + 1;
    frame0(32'h1234_0567, 1);
    wait_cyc(s + CSS + 7 * CD + 2);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_cyc(s + LAT);
    bus0.start = 1'b1;
    repeat (2) @(negedge clk);
    bus0.start = 1'b0;
    wait_idle(0, "idle_t2");
    repeat (3) begin
      @(negedge clk);
      check("not_queued0", 64'(bus0.busy), 64'(0));
    end
    check("pending_t2", 64'(exp_q.size()), 64'(0));
    frame0({16'($urandom), 16'($urandom)}, 1);
    wait_idle(0, "idle_t2b");

    // start held for three back-to-back frames.
    s = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      w = {16'($urandom), pats[k]};
      word_q.push_back(w);
      exp_q.push_back(w);
      edge_q.push_back(s + k * PERIOD + LAT);
    end
    bus0.start = 1'b1;
    wait_cyc(s + 1);
    btb_mode = 1'b1;
    wait_cyc(s + 2 * PERIOD);
    bus0.start = 1'b0;
    wait_idle(0, "idle_t3");
    btb_mode = 1'b0;
    check("pending_t3", 64'(exp_q.size()), 64'(0));

    // Reset in the middle of bit 10 aborts the frame without a valid.
    s = cyc + 1;
    word_q.push_back(32'hFFFF_FFFF);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_cyc(s + CSS + 10 * CD + 3);
    #2 rst = 1'b1;
    #1;
    check("abort_cs_n0", 64'(cs_n0), 64'(1));
    check("abort_sck0", 64'(sck0), 64'(0));
    check("abort_busy0", 64'(bus0.busy), 64'(0));
    check("abort_valid0", 64'(bus0.valid), 64'(0));
    check("abort_data0", 64'(bus0.data_out), 64'(0));
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    repeat (LAT + 10) @(negedge clk);
    check("abort_idle0", 64'(bus0.busy), 64'(0));
    frame0(32'h0321_0CDE, 1);
    wait_idle(0, "idle_t4");

`ifdef SPI_ADC_LEADZERO_CHECK_EN
    // Leading-zero flag set then cleared.
    frame0({16'h8123, 16'h0001}, 1);
    wait_idle(0, "idle_lz1");
    check("lz_set0", 64'(bus0.lz_err), 64'(1));
    frame0({16'h0123, 16'h0001}, 1);
    wait_idle(0, "idle_lz2");
    check("lz_clr0", 64'(bus0.lz_err), 64'(0));
`endif

    // Randomized frames with random start widths and gaps.
    for (int k = 0; k < 8; k++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w = w & 32'h0FFF_0FFF;
      frame0(w, $urandom_range(1, 3));
      wait_idle(0, "idle_rand");
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    check("pending_rand", 64'(exp_q.size()), 64'(0));

    // Small configuration: sck toggles every clk, 26-cycle latency.
    s = cyc + 1;
    frame1(12'hA5A);
    wait_cyc(s + 1);
    for (int k = 0; k < DW1 * CD1; k++) begin
      check("sck1_toggle", 64'(sck1), 64'(k % 2 == 0));
      check("cs_n1_low", 64'(cs_n1), 64'(0));
      @(negedge clk);
    end
    wait_idle(1, "idle_dut1");
    for (int k = 0; k < 3; k++) begin
      w1 = DW1'($urandom);
      frame1(w1);
      wait_idle(1, "idle_dut1_rand");
    end
    check("pending_dut1", 64'(exp1_q.size()), 64'(0));
    check("pending_end0", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_adc_master.md
Name: spi_adc_master

Overview:
- Parametrised SPI receive master for serial ADCs such as the PMOD AD1 (two AD7476 converters sharing CS and SCLK, one MISO each).
- Performs one framed conversion per start request. Each frame asserts cs_n, generates SCLK from clk, and shifts DATA_W bits MSB-first from N_CH data lines in parallel.
- Presents all channel words at once with a one-cycle valid pulse.
- Sits between the board ADC pins and the sample-processing logic, for example the servo control loop.

Parameters:
- DATA_W, 16: bits per frame per channel (>=2).
- N_CH, 2: number of parallel MISO lines/channels (>=1).
- CLK_DIV, 8: clk cycles per SCLK period; even, >=2. Default gives 12.5 MHz from 100 MHz.
- CS_SETUP, 2: clk cycles from cs_n falling to the first SCLK rising edge (>=1).
- CS_HOLD, 2: clk cycles cs_n is held high after the frame before a new start is accepted (>=1).

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: reset, asynchronous, active-high.
- start, in, 1: conversion request, sampled high in IDLE.
- miso, in, N_CH: serial data, bit i = channel i.
- cs_n, out, 1: chip select, active low, registered.
- sck, out, 1: serial clock, CPOL=0, registered, glitch-free.
- busy, out, 1: high whenever state != IDLE.
- valid, out, 1: one-cycle pulse; data_out updated this cycle.
- data_out, out, N_CH*DATA_W: channel i in bits [i*DATA_W +: DATA_W], MSB = first bit received.

Behaviour:
- Reset values: cs_n=1, sck=0, busy=0, valid=0, data_out=0; all counters and shift registers cleared.
- Reset mid-frame aborts immediately to IDLE with the reset values. No valid is produced.
- IDLE
  - cs_n=1, sck=0.
  - start=1 on a clk edge → SETUP; cs_n goes low on that same edge.
- SETUP
  - Lasts CS_SETUP cycles with sck=0, then → SHIFT.
- SHIFT
  - Phase counter p runs 0..CLK_DIV-1; bit counter b runs 0..DATA_W-1.
  - sck=1 for p in [0, CLK_DIV/2), sck=0 for p in [CLK_DIV/2, CLK_DIV).
  - On the edge ending p=CLK_DIV-1 (end of the low half, just after the slave's falling-edge update), every channel shifts in miso[i] at the LSB and b increments.
  - After bit DATA_W-1 is sampled:
    - → HOLD
    - cs_n=1 and sck=0 on the same edge
    - data_out loads all shift registers
    - valid=1 for exactly the next cycle
  - Duration of SHIFT: DATA_W*CLK_DIV cycles.
- HOLD
  - Lasts CS_HOLD cycles with cs_n=1, then → IDLE.
  - start is ignored throughout HOLD.
- Latency: with start seen at edge 0, valid is high in the cycle after edge CS_SETUP + DATA_W*CLK_DIV. Defaults: valid in cycle 130..131.
- start asserted while busy is ignored and not queued.
- start held high continuously gives back-to-back frames separated by CS_HOLD + 1 idle cycles of cs_n high.
- data_out holds its value between valid pulses.
- Parameter checks: illegal parameter values (odd CLK_DIV, zero counts) are flagged with a simulation-time error at elaboration.

Optional Feature:
- Macro: SPI_ADC_LEADZERO_CHECK_EN.
- When defined:
  - Adds output port lz_err (1 bit, reset 0). Parameter LZ_BITS (default 4) gives the number of leading bits that must be zero.
  - On each valid, lz_err is set to 1 if any channel's top LZ_BITS bits are non-zero, and cleared to 0 otherwise.
  - lz_err is valid with, and held like, data_out.
- When undefined: the port and logic are absent; behaviour is otherwise identical.

Test Plan:
- Defaults, start pulse, miso[0] driving 0x0ABC and miso[1] driving 0x0F0F on SCLK falling edges → one valid pulse in the latency cycle.
  - data_out=0x0F0F_0ABC.
  - 16 sck rising edges, each sck high 4 / low 4 clks.
  - cs_n low for exactly 2+128 cycles.
- start re-pulsed at SHIFT bit 7 and again during HOLD → ignored; exactly one valid; next start accepted only after busy=0.
- start held high for 3 frames with miso patterns 0x0001, 0x0800, 0x0FFF → 3 valids; data_out channel 0 matches each pattern; cs_n high for 3 cycles between frames.
- rst asserted at SHIFT bit 10, then a new frame → outputs at reset values immediately; no valid; the next frame returns correct data unaffected by the aborted bits.
- Parameter set DATA_W=12, N_CH=1, CLK_DIV=2, CS_SETUP=1 → sck toggles every clk; valid 1+1+24=26 cycles after start; data_out 12 bits correct for 0xA5A.
- With SPI_ADC_LEADZERO_CHECK_EN, channel 1 returns 0x8123 → lz_err=1 with valid; the next frame returning 0x0123 → lz_err=0.
